// File: rtl/lsf_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsf_mac_pkg
// Purpose  : Shared width defaults and accumulator saturation limits for the
//            LSF multiply-accumulate pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package lsf_mac_pkg;

    localparam int LSF_MAC_A_W   = 13;
    localparam int LSF_MAC_B_W   = 18;
    localparam int LSF_MAC_ACC_W = 38;

    // Width of the raw limit word; callers truncate it to their ACC_W.
    localparam int LSF_MAC_LIM_W = 128;

    // Saturation limit of an acc_w-bit signed accumulator.
    // neg=0 returns 2^(acc_w-1)-1, neg=1 returns -2^(acc_w-1). The value is
    // correct in its low acc_w bits, so a size cast to acc_w bits is exact.
    function automatic logic [LSF_MAC_LIM_W-1:0] lsf_mac_sat_lim(input int acc_w,
                                                                 input logic neg);
        logic [LSF_MAC_LIM_W-1:0] max_v;
        max_v = (LSF_MAC_LIM_W'(1) << (acc_w - 1)) - LSF_MAC_LIM_W'(1);
        return neg ? ~max_v : max_v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsf_mac_mul_pipe.sv
`default_nettype none
// ============================================================================
// Module   : lsf_mac_mul_pipe
// Purpose  : NUM_STAGE-deep enabled mixed-sign multiplier (unsigned a times
//            signed b) carrying valid/first/last sideband alongside the
//            product. Only the first register sees the raw product; the
//            following registers give synthesis room to retime the multiplier.
// Ports    : clk, rst_n        clock, asynchronous active-low reset
//            i_en              advance all stages
//            i_valid/i_first/i_last, i_a, i_b   input beat
//            o_valid/o_first/o_last, o_prod     beat leaving the last stage
// Revision : 1.0 - initial release
// ============================================================================
module lsf_mac_mul_pipe
    import lsf_mac_pkg::*;
#(
    parameter int A_W       = LSF_MAC_A_W,
    parameter int B_W       = LSF_MAC_B_W,
    parameter int P_W       = A_W + B_W,
    parameter int NUM_STAGE = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_en,
    input  logic                  i_valid,
    input  logic                  i_first,
    input  logic                  i_last,
    input  logic [A_W-1:0]        i_a,
    input  logic signed [B_W-1:0] i_b,
    output logic                  o_valid,
    output logic                  o_first,
    output logic                  o_last,
    output logic signed [P_W-1:0] o_prod
);

    // Zero-extend a, sign-extend b, both to P_W; the exact product of an
    // A_W-bit unsigned and a B_W-bit signed value fits in A_W+B_W bits.
    logic signed [P_W-1:0] w_a_s;
    logic signed [P_W-1:0] w_b_s;
    logic signed [P_W-1:0] w_prod;

    assign w_a_s  = P_W'($signed({1'b0, i_a}));
    assign w_b_s  = P_W'(i_b);
    assign w_prod = w_a_s * w_b_s;

    logic signed [P_W-1:0] r_prod [NUM_STAGE];
    logic [NUM_STAGE-1:0]  r_valid;
    logic [NUM_STAGE-1:0]  r_first;
    logic [NUM_STAGE-1:0]  r_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prod[0]  <= '0;
            r_valid[0] <= 1'b0;
            r_first[0] <= 1'b0;
            r_last[0]  <= 1'b0;
        end else if (i_en) begin
            r_prod[0]  <= w_prod;
            r_valid[0] <= i_valid;
            r_first[0] <= i_first;
            r_last[0]  <= i_last;
        end
    end

    generate
        for (genvar gi = 1; gi < NUM_STAGE; gi++) begin : g_stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_prod[gi]  <= '0;
                    r_valid[gi] <= 1'b0;
                    r_first[gi] <= 1'b0;
                    r_last[gi]  <= 1'b0;
                end else if (i_en) begin
                    r_prod[gi]  <= r_prod[gi-1];
                    r_valid[gi] <= r_valid[gi-1];
                    r_first[gi] <= r_first[gi-1];
                    r_last[gi]  <= r_last[gi-1];
                end
            end
        end
    endgenerate

    assign o_prod  = r_prod[NUM_STAGE-1];
    assign o_valid = r_valid[NUM_STAGE-1];
    assign o_first = r_first[NUM_STAGE-1];
    assign o_last  = r_last[NUM_STAGE-1];

endmodule
`default_nettype wire

// File: rtl/lsf_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : lsf_mac_pipe
// Purpose  : Pipelined mixed-sign multiply-accumulate for the Legendre segment
//            finder. Products of a framed burst are summed and one signed sum
//            per frame is emitted on a valid/ready stream.
// Ports    : ap_clk, ap_rst_n           clock, asynchronous active-low reset
//            in_valid/in_ready          input beat handshake
//            in_a (unsigned), in_b (signed), in_first, in_last
//            out_valid/out_ready        frame sum handshake
//            out_p (signed ACC_W), out_ovf  frame sum, saturation flag
// Config   : LSF_MAC_SAT_EN defined   -> saturating accumulate, sticky out_ovf
//            LSF_MAC_SAT_EN undefined -> wrap modulo 2^ACC_W, out_ovf = 0
// Revision : 1.0 - initial release
// ============================================================================
module lsf_mac_pipe
    import lsf_mac_pkg::*;
#(
    parameter int A_W       = LSF_MAC_A_W,
    parameter int B_W       = LSF_MAC_B_W,
    parameter int P_W       = A_W + B_W,
    parameter int ACC_W     = LSF_MAC_ACC_W,
    parameter int NUM_STAGE = 3
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [A_W-1:0]          in_a,
    input  logic signed [B_W-1:0]   in_b,
    input  logic                    in_first,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] out_p,
    output logic                    out_ovf
);

    logic                    r_out_valid;
    logic signed [ACC_W-1:0] r_out_p;
    logic signed [ACC_W-1:0] r_acc;
    logic                    r_open;

    // Whole pipeline stalls only while a result is held and not taken; this
    // is the sole path from out_ready to in_ready.
    logic w_en;
    assign w_en     = ~r_out_valid | out_ready;
    assign in_ready = w_en;

    logic                  w_mv;
    logic                  w_mf;
    logic                  w_ml;
    logic signed [P_W-1:0] w_mp;

    lsf_mac_mul_pipe #(
        .A_W       (A_W),
        .B_W       (B_W),
        .P_W       (P_W),
        .NUM_STAGE (NUM_STAGE)
    ) u_mul (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .i_en    (w_en),
        .i_valid (in_valid),
        .i_first (in_first),
        .i_last  (in_last),
        .i_a     (in_a),
        .i_b     (in_b),
        .o_valid (w_mv),
        .o_first (w_mf),
        .o_last  (w_ml),
        .o_prod  (w_mp)
    );

    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_add;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_start;

    assign w_prod_ext = ACC_W'(w_mp);
    // A beat arriving with no open frame starts one, as does an explicit first
    // (which silently drops any partial sum of an aborted frame).
    assign w_start    = w_mf | ~r_open;
    assign w_add      = r_acc + w_prod_ext;

`ifdef LSF_MAC_SAT_EN
    localparam logic signed [ACC_W-1:0] c_sat_max = ACC_W'(lsf_mac_sat_lim(ACC_W, 1'b0));
    localparam logic signed [ACC_W-1:0] c_sat_min = ACC_W'(lsf_mac_sat_lim(ACC_W, 1'b1));

    logic r_ovf;
    logic r_out_ovf;
    logic w_add_ovf;
    logic w_ovf_next;

    // Signed overflow: operands agree in sign but the sum does not.
    assign w_add_ovf = (r_acc[ACC_W-1] == w_prod_ext[ACC_W-1]) &&
                       (w_add[ACC_W-1] != r_acc[ACC_W-1]);

    always_comb begin
        w_sum      = w_add;
        w_ovf_next = r_ovf;
        if (w_start) begin
            w_sum      = w_prod_ext;
            w_ovf_next = 1'b0;
        end else if (w_add_ovf) begin
            w_sum      = r_acc[ACC_W-1] ? c_sat_min : c_sat_max;
            w_ovf_next = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_ovf     <= 1'b0;
            r_out_ovf <= 1'b0;
        end else if (w_en && w_mv) begin
            r_ovf <= w_ovf_next;
            if (w_ml) begin
                r_out_ovf <= w_ovf_next;
            end
        end
    end

    assign out_ovf = r_out_ovf;
`else
    assign w_sum   = w_start ? w_prod_ext : w_add;
    assign out_ovf = 1'b0;
`endif

    // Accumulate stage and output register share one enable; when a held
    // result is taken the next frame sum may load in the same cycle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_acc       <= '0;
            r_open      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_p     <= '0;
        end else if (w_en) begin
            if (w_mv) begin
                r_acc  <= w_sum;
                r_open <= ~w_ml;
            end
            r_out_valid <= w_mv & w_ml;
            if (w_mv && w_ml) begin
                r_out_p <= w_sum;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_p     = r_out_p;

endmodule
`default_nettype wire

// File: tb/tb_lsf_mac_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsf_mac_pipe
// Purpose  : Self-checking bench for lsf_mac_pipe (ACC_W=32, NUM_STAGE=3).
//            Directed scenarios plus randomized frames, checked against a
//            frame-level reference model kept in this file.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsf_mac_pipe;

    localparam int C_A_W   = 13;
    localparam int C_B_W   = 18;
    localparam int C_ACC_W = 32;
    localparam int C_STG   = 3;

    logic                      clk;
    logic                      rst_n;
    logic                      in_valid;
    logic                      in_ready;
    logic [C_A_W-1:0]          in_a;
    logic signed [C_B_W-1:0]   in_b;
    logic                      in_first;
    logic                      in_last;
    logic                      out_valid;
    logic                      out_ready;
    logic signed [C_ACC_W-1:0] out_p;
    logic                      out_ovf;

    lsf_mac_pipe #(
        .A_W       (C_A_W),
        .B_W       (C_B_W),
        .ACC_W     (C_ACC_W),
        .NUM_STAGE (C_STG)
    ) dut (
        .ap_clk    (clk),
        .ap_rst_n  (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    // ---------------- reference model (frame level) ----------------
    typedef struct {
        longint p;
        bit     ovf;
    } exp_t;

    exp_t   exp_q[$];
    longint m_acc  = 0;
    bit     m_open = 1'b0;
    bit     m_ovf  = 1'b0;

    function automatic longint wrap_acc(input longint v);
        longint t;
        t = v <<< (64 - C_ACC_W);
        return t >>> (64 - C_ACC_W);
    endfunction

    function automatic void model_beat(input longint a, input longint b, input bit f, input bit l);
        longint p;
        longint s;
        longint mx;
        longint mn;
        p  = a * b;
        mx = (longint'(1) <<< (C_ACC_W - 1)) - 1;
        mn = -mx - 1;
        if (f || !m_open) begin
            m_acc  = p;
            m_ovf  = 1'b0;
            m_open = 1'b1;
        end else begin
            s = m_acc + p;
`ifdef LSF_MAC_SAT_EN
            if (s > mx) begin s = mx; m_ovf = 1'b1; end
            else if (s < mn) begin s = mn; m_ovf = 1'b1; end
            m_acc = s;
`else
            m_acc = wrap_acc(s);
`endif
        end
        if (l) begin
            exp_q.push_back('{p: m_acc, ovf: m_ovf});
            m_open = 1'b0;
        end
    endfunction

    // Output check first, then record the beat that the next edge accepts.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                chk("pending_frame", longint'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    chk("out_p", out_p, exp_q[0].p);
                    chk("out_ovf", longint'(out_ovf), longint'(exp_q[0].ovf));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            if (in_valid && in_ready)
                model_beat(longint'(in_a), longint'(in_b), in_first, in_last);
        end
    end

    // ---------------- stimulus helpers (enter/leave at posedge+1) ----------------
    task automatic send_beat(input int a, input int b, input bit f, input bit l, input bit rnd);
        int guard;
        in_valid = 1'b1;
        in_a     = C_A_W'(a);
        in_b     = C_B_W'(b);
        in_first = f;
        in_last  = l;
        guard    = 0;
        @(negedge clk);
        while (!in_ready && guard < 64) begin
            @(posedge clk); #1;
            if (rnd) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) chk("accept_timeout", longint'(in_ready), 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (rnd) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_out(output longint p, output bit o);
        int guard;
        guard = 0;
        while (!out_valid && guard < 64) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 64) chk("wait_out_timeout", longint'(out_valid), 1);
        p = out_p;
        o = out_ovf;
    endtask

    task automatic drain();
        int guard;
        out_ready = 1'b1;
        guard     = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 200) chk("drain_timeout", exp_q.size(), 0);
        repeat (2) begin @(posedge clk); #1; end
    endtask

    initial begin
        longint p;
        bit     o;
        int     lat;
        longint sat_p;
        bit     sat_o;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", longint'(out_valid), 0);
        chk("rst_out_p", out_p, 0);
        chk("rst_out_ovf", longint'(out_ovf), 0);
        chk("rst_in_ready", longint'(in_ready), 1);
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end

        // Single-beat frame and latency.
        in_valid = 1'b1; in_a = 13'd8191; in_b = C_B_W'(-131072);
        in_first = 1'b1; in_last = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", lat, 4);
        chk("single_p", out_p, -1073610752);
        chk("single_ovf", longint'(out_ovf), 0);
        drain();

        // Three-beat frame, back to back.
        send_beat(100, 5, 1'b1, 1'b0, 1'b0);
        send_beat(200, -3, 1'b0, 1'b0, 1'b0);
        send_beat(1, 7, 1'b0, 1'b1, 1'b0);
        wait_out(p, o);
        chk("frame_sum", p, -93);
        drain();

        // Backpressure with two single-beat frames.
        out_ready = 1'b0;
        send_beat(3, 4, 1'b1, 1'b1, 1'b0);
        send_beat(2, -2, 1'b1, 1'b1, 1'b0);
        wait_out(p, o);
        chk("bp_first", p, 12);
        repeat (10) begin
            @(posedge clk); #1;
            chk("bp_hold_p", out_p, 12);
            chk("bp_in_ready", longint'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_next_valid", longint'(out_valid), 1);
        chk("bp_next_p", out_p, -4);
        drain();

        // Abort: new first while a frame is open.
        send_beat(10, 10, 1'b1, 1'b0, 1'b0);
        send_beat(1, 1, 1'b1, 1'b1, 1'b0);
        wait_out(p, o);
        chk("abort_p", p, 1);
        @(posedge clk); #1;
        chk("abort_no_second", longint'(out_valid), 0);
        drain();

        // Accumulator overflow.
`ifdef LSF_MAC_SAT_EN
        sat_p = 2147483647;
        sat_o = 1'b1;
`else
        sat_p = wrap_acc(longint'(3) * 8191 * 131071);
        sat_o = 1'b0;
`endif
        send_beat(8191, 131071, 1'b1, 1'b0, 1'b0);
        send_beat(8191, 131071, 1'b0, 1'b0, 1'b0);
        send_beat(8191, 131071, 1'b0, 1'b1, 1'b0);
        wait_out(p, o);
        chk("ovf_p", p, sat_p);
        chk("ovf_flag", longint'(o), longint'(sat_o));
        drain();

        // Randomized frames, bubbles and backpressure.
        for (int n = 0; n < 400; n++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 4) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end else begin
                send_beat(int'($urandom_range(0, 8191)),
                          int'($signed(C_B_W'($urandom))),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 3) == 0),
                          1'b1);
            end
        end
        drain();
        chk("random_drained", exp_q.size(), 0);

        // Reset with a result pending and a frame open.
        out_ready = 1'b0;
        send_beat(7, 7, 1'b1, 1'b1, 1'b0);
        send_beat(4, 4, 1'b1, 1'b0, 1'b0);
        wait_out(p, o);
        chk("pre_rst_p", p, 49);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        m_open    = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("rst_async_valid", longint'(out_valid), 0);
        chk("rst_async_p", out_p, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_beat(5, 5, 1'b1, 1'b1, 1'b0);
        wait_out(p, o);
        chk("post_rst_p", p, 25);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
